// File: rtl/antares_memory_arbiter_if.sv
// Bus bundle for the memory arbiter: LSU instruction port, LSU data port and the shared slave port.
// The slave modport is the arbiter's view; the master modport is the LSU/slave environment's view.
interface antares_memory_arbiter_if;
    logic [31:0] iport_address;
    logic [3:0]  iport_wr;
    logic        iport_enable;
    logic [31:0] iport_data_o;
    logic        iport_ready;
    logic        iport_error;

    logic [31:0] dport_address;
    logic [31:0] dport_data_i;
    logic [3:0]  dport_wr;
    logic        dport_enable;
    logic [31:0] dport_data_o;
    logic        dport_ready;
    logic        dport_error;

    logic [31:0] mem_address;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_wr;
    logic        mem_enable;
    logic [31:0] mem_data_i;
    logic        mem_ready;
    logic        mem_error;

    modport slave (
        input  iport_address, iport_wr, iport_enable,
        output iport_data_o, iport_ready, iport_error,
        input  dport_address, dport_data_i, dport_wr, dport_enable,
        output dport_data_o, dport_ready, dport_error,
        output mem_address, mem_data_o, mem_wr, mem_enable,
        input  mem_data_i, mem_ready, mem_error
    );

    modport master (
        output iport_address, iport_wr, iport_enable,
        input  iport_data_o, iport_ready, iport_error,
        output dport_address, dport_data_i, dport_wr, dport_enable,
        input  dport_data_o, dport_ready, dport_error,
        input  mem_address, mem_data_o, mem_wr, mem_enable,
        output mem_data_i, mem_ready, mem_error
    );
endinterface

// File: rtl/antares_memory_arbiter.sv
// Merges the LSU instruction and data ports onto one enable/ready memory port, data port first,
// with a bus-timeout that turns a silent slave into a bus error.
module antares_memory_arbiter #(
    parameter int TIMEOUT  = 255,
    parameter int TO_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    antares_memory_arbiter_if.slave bus
);

    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, REL_I, REL_D} state_t;

    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t              r_state;
    state_t              w_next;
    logic [TO_WIDTH-1:0] r_cnt;
    logic [31:0]         r_mem_address;
    logic [31:0]         r_mem_data;
    logic [3:0]          r_mem_wr;
    logic                r_mem_enable;
    logic [31:0]         r_i_data;
    logic                r_i_ready;
    logic                r_i_error;
    logic [31:0]         r_d_data;
    logic                r_d_ready;
    logic                r_d_error;

    logic w_grant_i;
    logic w_grant_d;
    logic w_timeout;
    logic w_fail;
    logic w_done;
    logic w_is_read;

    // A timeout is handled exactly like a slave error, and an error beats a simultaneous ready.
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST);
    assign w_fail    = bus.mem_error | w_timeout;
    assign w_done    = bus.mem_ready & ~w_fail;
    assign w_is_read = (r_mem_wr == 4'b0000);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        case (r_state)
            IDLE: begin
                // Wait for the slave to finish its own release before starting anything new.
                if (!bus.mem_ready && !bus.mem_error) begin
                    if (bus.dport_enable) begin
                        w_grant_d = 1'b1;
                        w_next    = BUSY_D;
                    end else if (bus.iport_enable) begin
                        w_grant_i = 1'b1;
                        w_next    = BUSY_I;
                    end
                end
            end
            BUSY_I:  if (w_fail || bus.mem_ready) w_next = REL_I;
            BUSY_D:  if (w_fail || bus.mem_ready) w_next = REL_D;
            REL_I:   if (!bus.iport_enable) w_next = IDLE;
            REL_D:   if (!bus.dport_enable) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_mem_wr      <= '0;
            r_mem_enable  <= 1'b0;
            r_i_data      <= '0;
            r_i_ready     <= 1'b0;
            r_i_error     <= 1'b0;
            r_d_data      <= '0;
            r_d_ready     <= 1'b0;
            r_d_error     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_mem_address <= bus.dport_address;
                        r_mem_wr      <= bus.dport_wr;
                        r_mem_data    <= bus.dport_data_i;
                        r_mem_enable  <= 1'b1;
                        r_cnt         <= '0;
                    end else if (w_grant_i) begin
                        r_mem_address <= bus.iport_address;
                        r_mem_wr      <= bus.iport_wr;
                        r_mem_data    <= '0;
                        r_mem_enable  <= 1'b1;
                        r_cnt         <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_fail || bus.mem_ready) begin
                        r_mem_enable <= 1'b0;
                        r_mem_wr     <= 4'b0000;
                    end
                    if (r_state == BUSY_I) begin
                        if (w_fail) r_i_error <= 1'b1;
                        if (w_done) r_i_ready <= 1'b1;
                        if (w_done && w_is_read) r_i_data <= bus.mem_data_i;
                    end else begin
                        if (w_fail) r_d_error <= 1'b1;
                        if (w_done) r_d_ready <= 1'b1;
                        if (w_done && w_is_read) r_d_data <= bus.mem_data_i;
                    end
                end
                REL_I: begin
                    if (!bus.iport_enable) begin
                        r_i_ready <= 1'b0;
                        r_i_error <= 1'b0;
                    end
                end
                REL_D: begin
                    if (!bus.dport_enable) begin
                        r_d_ready <= 1'b0;
                        r_d_error <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_address  = r_mem_address;
    assign bus.mem_data_o   = r_mem_data;
    assign bus.mem_wr       = r_mem_wr;
    assign bus.mem_enable   = r_mem_enable;
    assign bus.iport_data_o = r_i_data;
    assign bus.iport_ready  = r_i_ready;
    assign bus.iport_error  = r_i_error;
    assign bus.dport_data_o = r_d_data;
    assign bus.dport_ready  = r_d_ready;
    assign bus.dport_error  = r_d_error;

endmodule

// File: tb/tb_antares_memory_arbiter.sv
// Directed bench for antares_memory_arbiter; the slave and both LSU ports are driven cycle by cycle.
module tb_antares_memory_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    antares_memory_arbiter_if bus ();

    antares_memory_arbiter #(.TIMEOUT(4), .TO_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iport_address = '0; bus.iport_wr = '0; bus.iport_enable = 1'b0;
        bus.dport_address = '0; bus.dport_data_i = '0; bus.dport_wr = '0; bus.dport_enable = 1'b0;
        bus.mem_data_i = '0; bus.mem_ready = 1'b0; bus.mem_error = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total++; if (bus.mem_enable !== 1'b0) begin bad++; $display("FAIL reset_mem_enable got=%b exp=0", bus.mem_enable); end
        total++; if (bus.mem_wr !== 4'b0000) begin bad++; $display("FAIL reset_mem_wr got=%b exp=0000", bus.mem_wr); end
        total++; if (bus.mem_address !== 32'h0) begin bad++; $display("FAIL reset_mem_address got=%h exp=0", bus.mem_address); end
        total++; if ({bus.iport_ready, bus.iport_error, bus.dport_ready, bus.dport_error} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", {bus.iport_ready, bus.iport_error, bus.dport_ready, bus.dport_error}); end
        total++; if ({bus.iport_data_o, bus.dport_data_o} !== 64'h0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", {bus.iport_data_o, bus.dport_data_o}); end
    endtask

    // Simultaneous requests: data port wins, instruction port is served after the release.
    task automatic test_priority();
        bus.iport_address = 32'h0000_0100; bus.iport_wr = 4'b0000; bus.iport_enable = 1'b1;
        bus.dport_address = 32'h1000_0040; bus.dport_wr = 4'b0000; bus.dport_enable = 1'b1;
        tick();
        total++; if (bus.mem_enable !== 1'b1) begin bad++; $display("FAIL prio_grant_enable got=%b exp=1", bus.mem_enable); end
        total++; if (bus.mem_address !== 32'h1000_0040) begin bad++; $display("FAIL prio_grant_addr got=%h exp=10000040", bus.mem_address); end
        tick();
        total++; if (bus.dport_ready !== 1'b0) begin bad++; $display("FAIL prio_wait_ready got=%b exp=0", bus.dport_ready); end
        bus.mem_ready = 1'b1; bus.mem_data_i = 32'hDEAD_BEEF;
        tick();
        total++; if (bus.dport_ready !== 1'b1) begin bad++; $display("FAIL prio_d_ready got=%b exp=1", bus.dport_ready); end
        total++; if (bus.dport_data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL prio_d_data got=%h exp=deadbeef", bus.dport_data_o); end
        total++; if (bus.mem_enable !== 1'b0) begin bad++; $display("FAIL prio_d_drop_enable got=%b exp=0", bus.mem_enable); end
        total++; if (bus.iport_ready !== 1'b0) begin bad++; $display("FAIL prio_i_not_ready got=%b exp=0", bus.iport_ready); end
        bus.dport_enable = 1'b0;
        tick();
        total++; if (bus.dport_ready !== 1'b0) begin bad++; $display("FAIL prio_d_release got=%b exp=0", bus.dport_ready); end
        tick();
        total++; if (bus.mem_enable !== 1'b0) begin bad++; $display("FAIL prio_hold_while_slave_ready got=%b exp=0", bus.mem_enable); end
        bus.mem_ready = 1'b0;
        tick();
        total++; if (bus.mem_enable !== 1'b1) begin bad++; $display("FAIL prio_i_grant_enable got=%b exp=1", bus.mem_enable); end
        total++; if (bus.mem_address !== 32'h0000_0100) begin bad++; $display("FAIL prio_i_grant_addr got=%h exp=00000100", bus.mem_address); end
        bus.mem_ready = 1'b1; bus.mem_data_i = 32'h1357_9BDF;
        tick();
        total++; if (bus.iport_ready !== 1'b1) begin bad++; $display("FAIL prio_i_ready got=%b exp=1", bus.iport_ready); end
        total++; if (bus.iport_data_o !== 32'h1357_9BDF) begin bad++; $display("FAIL prio_i_data got=%h exp=13579bdf", bus.iport_data_o); end
        total++; if (bus.dport_data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL prio_d_data_hold got=%h exp=deadbeef", bus.dport_data_o); end
        bus.mem_ready = 1'b0; bus.iport_enable = 1'b0;
        tick();
        total++; if (bus.iport_ready !== 1'b0) begin bad++; $display("FAIL prio_i_release got=%b exp=0", bus.iport_ready); end
    endtask

    task automatic test_write();
        bus.dport_address = 32'h0000_0020; bus.dport_wr = 4'b0100;
        bus.dport_data_i = 32'hABAB_ABAB; bus.dport_enable = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            total++; if ({bus.mem_enable, bus.mem_wr} !== 5'b1_0100) begin
                bad++; $display("FAIL wr_stable_ctl cyc=%0d got=%b exp=10100", c, {bus.mem_enable, bus.mem_wr}); end
            total++; if (bus.mem_data_o !== 32'hABAB_ABAB) begin
                bad++; $display("FAIL wr_stable_data cyc=%0d got=%h exp=abababab", c, bus.mem_data_o); end
            if (c < 2) tick();
        end
        bus.mem_ready = 1'b1; bus.mem_data_i = 32'h5555_5555;
        tick();
        total++; if (bus.dport_ready !== 1'b1) begin bad++; $display("FAIL wr_ready got=%b exp=1", bus.dport_ready); end
        total++; if (bus.dport_data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_data_unchanged got=%h exp=deadbeef", bus.dport_data_o); end
        total++; if ({bus.mem_enable, bus.mem_wr} !== 5'b0_0000) begin
            bad++; $display("FAIL wr_idle_wr got=%b exp=00000", {bus.mem_enable, bus.mem_wr}); end
        bus.mem_ready = 1'b0; bus.dport_enable = 1'b0; bus.dport_wr = 4'b0000;
        tick();
        total++; if (bus.dport_ready !== 1'b0) begin bad++; $display("FAIL wr_release got=%b exp=0", bus.dport_ready); end
    endtask

    task automatic test_error();
        bus.iport_address = 32'h0000_0200; bus.iport_enable = 1'b1;
        tick();
        total++; if (bus.mem_address !== 32'h0000_0200) begin bad++; $display("FAIL err_grant_addr got=%h exp=00000200", bus.mem_address); end
        bus.mem_ready = 1'b1; bus.mem_error = 1'b1; bus.mem_data_i = 32'hFFFF_0000;
        tick();
        total++; if ({bus.iport_error, bus.iport_ready} !== 2'b10) begin
            bad++; $display("FAIL err_flags got=%b exp=10", {bus.iport_error, bus.iport_ready}); end
        total++; if (bus.iport_data_o !== 32'h1357_9BDF) begin bad++; $display("FAIL err_data_hold got=%h exp=13579bdf", bus.iport_data_o); end
        total++; if (bus.mem_enable !== 1'b0) begin bad++; $display("FAIL err_drop_enable got=%b exp=0", bus.mem_enable); end
        bus.mem_ready = 1'b0; bus.mem_error = 1'b0;
        tick();
        total++; if (bus.iport_error !== 1'b1) begin bad++; $display("FAIL err_held got=%b exp=1", bus.iport_error); end
        bus.iport_enable = 1'b0;
        tick();
        total++; if (bus.iport_error !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b exp=0", bus.iport_error); end
    endtask

    task automatic test_timeout();
        bus.dport_address = 32'h0000_0300; bus.dport_wr = 4'b0000; bus.dport_enable = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            total++; if ({bus.mem_enable, bus.dport_error} !== 2'b10) begin
                bad++; $display("FAIL to_pending cyc=%0d got=%b exp=10", c, {bus.mem_enable, bus.dport_error}); end
            tick();
        end
        total++; if ({bus.mem_enable, bus.dport_error, bus.dport_ready} !== 3'b010) begin
            bad++; $display("FAIL to_fired got=%b exp=010", {bus.mem_enable, bus.dport_error, bus.dport_ready}); end
        bus.mem_ready = 1'b1; bus.mem_data_i = 32'hBAD0_BAD0;
        tick();
        total++; if ({bus.dport_error, bus.dport_ready} !== 2'b10) begin
            bad++; $display("FAIL to_late_flags got=%b exp=10", {bus.dport_error, bus.dport_ready}); end
        total++; if (bus.dport_data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL to_late_data got=%h exp=deadbeef", bus.dport_data_o); end
        bus.dport_enable = 1'b0;
        tick();
        total++; if (bus.dport_error !== 1'b0) begin bad++; $display("FAIL to_release got=%b exp=0", bus.dport_error); end
        tick();
        total++; if ({bus.mem_enable, bus.dport_ready, bus.iport_ready} !== 3'b000) begin
            bad++; $display("FAIL to_idle_ignore got=%b exp=000", {bus.mem_enable, bus.dport_ready, bus.iport_ready}); end
        total++; if (bus.dport_data_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL to_idle_data got=%h exp=deadbeef", bus.dport_data_o); end
        bus.mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        bus.iport_address = 32'h0000_0400; bus.iport_enable = 1'b1;
        tick();
        bus.mem_ready = 1'b1; bus.mem_data_i = 32'h0F0F_0F0F;
        tick();
        bus.mem_ready = 1'b0;
        total++; if (bus.iport_data_o !== 32'h0F0F_0F0F) begin bad++; $display("FAIL hold_data got=%h exp=0f0f0f0f", bus.iport_data_o); end
        for (int c = 0; c < 3; c++) begin
            total++; if (bus.iport_ready !== 1'b1) begin bad++; $display("FAIL hold_ready cyc=%0d got=%b exp=1", c, bus.iport_ready); end
            tick();
        end
        total++; if (bus.iport_ready !== 1'b1) begin bad++; $display("FAIL hold_ready_last got=%b exp=1", bus.iport_ready); end
        bus.iport_enable = 1'b0;
        tick();
        total++; if (bus.iport_ready !== 1'b0) begin bad++; $display("FAIL hold_release got=%b exp=0", bus.iport_ready); end
    endtask

    task automatic test_reset_busy();
        bus.dport_address = 32'h0000_0500; bus.dport_enable = 1'b1;
        bus.iport_address = 32'h0000_0600; bus.iport_enable = 1'b1;
        tick();
        total++; if (bus.mem_address !== 32'h0000_0500) begin bad++; $display("FAIL rb_grant_d got=%h exp=00000500", bus.mem_address); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.dport_enable = 1'b0;
        total++; if ({bus.mem_enable, bus.mem_wr, bus.mem_address, bus.mem_data_o} !== 69'h0) begin
            bad++; $display("FAIL rb_mem_cleared got=%h exp=0", {bus.mem_enable, bus.mem_wr, bus.mem_address, bus.mem_data_o}); end
        total++; if ({bus.dport_data_o, bus.iport_data_o, bus.dport_ready, bus.dport_error, bus.iport_ready, bus.iport_error} !== 68'h0) begin
            bad++; $display("FAIL rb_ports_cleared got=%h exp=0",
                {bus.dport_data_o, bus.iport_data_o, bus.dport_ready, bus.dport_error, bus.iport_ready, bus.iport_error}); end
        tick();
        total++; if ({bus.mem_enable, bus.mem_address} !== {1'b1, 32'h0000_0600}) begin
            bad++; $display("FAIL rb_i_grant got=%h exp=100000600", {bus.mem_enable, bus.mem_address}); end
        bus.mem_ready = 1'b1; bus.mem_data_i = 32'h0000_0066;
        tick();
        total++; if ({bus.iport_ready, bus.iport_data_o} !== {1'b1, 32'h0000_0066}) begin
            bad++; $display("FAIL rb_i_done got=%h exp=100000066", {bus.iport_ready, bus.iport_data_o}); end
        bus.mem_ready = 1'b0; bus.iport_enable = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_write();
        test_error();
        test_timeout();
        test_hold();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
